// File: rtl/br_pkg.sv
// br_pkg: shared states, cube one-hot constants and spawn coordinate widths for the red-ball controller
package br_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, LAUNCH, ACTIVE} brctl_state_t;
  localparam int X_W = 11;
  localparam int Y_W = 10;
  localparam int XY_W = X_W + Y_W;
  localparam logic [31:0] TOP = 32'h0000_0001;
  localparam logic [31:0] R02 = 32'h0000_0002;
  localparam logic [31:0] R04 = 32'h0000_0008;
  localparam logic [31:0] R07 = 32'h0000_0040;
  localparam logic [31:0] R11 = 32'h0000_0400;
  localparam logic [31:0] R16 = 32'h0000_8000;
  localparam logic [31:0] R22 = 32'h0020_0000;
  localparam logic [31:0] L03 = 32'h0000_0004;
  localparam logic [31:0] L06 = 32'h0000_0020;
  localparam logic [31:0] L10 = 32'h0000_0200;
  localparam logic [31:0] L15 = 32'h0000_4000;
  localparam logic [31:0] L21 = 32'h0010_0000;
  localparam logic [31:0] L28 = 32'h0800_0000;
  function automatic logic [31:0] cube_onehot(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : 32'd1 << (idx - 5'd1);
  endfunction
endpackage

// File: rtl/br_lfsr16.sv
// br_lfsr16: 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting while en is high
module br_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= SEED;
    else if (en) q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
endmodule

// File: rtl/boule_rouge_ctrl.sv
// boule_rouge_ctrl: red-ball spawn timing, launch and one-hot pyramid position tracking
module boule_rouge_ctrl
  import br_pkg::*;
#(
  parameter logic [31:0]     SPAWN_DELAY  = 32'd50_000_000,
  parameter logic [4:0]      JITTER_SHIFT = 5'd16,
  parameter logic [2:0]      N_MOVES      = 3'd7,
  parameter logic [XY_W-1:0] XY_SPAWN_L   = {11'd300, 10'd200},
  parameter logic [XY_W-1:0] XY_SPAWN_R   = {11'd300, 10'd280},
  parameter logic [15:0]     LFSR_SEED    = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            e_start_qb,
  input  logic            e_pause_qb,
  input  logic            e_resume_qb,
  input  logic            done_move,
  input  logic            br_kill,
  output logic            e_enable_br,
  output logic [6:0]      e_move_br,
  output logic [XY_W-1:0] e_XY0_br,
  output logic            br_active,
  output logic [31:0]     br_cube,
  output logic [2:0]      br_step
);
  brctl_state_t state;
  logic paused, side;
  logic [31:0] timer, delay;
  logic [15:0] lfsr;
  logic [2:0] row, nrow, nstep;
  logic [4:0] idx, nidx;
  br_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .en(!paused), .q(lfsr));
  always_comb begin
    delay = SPAWN_DELAY + (32'(lfsr[3:0]) << JITTER_SHIFT);
    nstep = br_step + 3'd1;
    nrow = (br_step == 3'd0) ? 3'd2 : row + 3'd1;
    nidx = (br_step == 3'd0) ? 5'd2 + 5'(side)
         : (row == 3'd7 || idx == 5'd0) ? 5'd0
         : idx + 5'(row) + 5'(e_move_br[br_step - 3'd1]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      paused <= 1'b0;
      timer <= 32'd0;
      side <= 1'b0;
      row <= 3'd0;
      idx <= 5'd0;
      e_enable_br <= 1'b0;
      e_move_br <= 7'd0;
      e_XY0_br <= '0;
      br_active <= 1'b0;
      br_cube <= 32'd0;
      br_step <= 3'd0;
    end else if (e_start_qb) begin
      state <= WAIT;
      paused <= 1'b0;
      timer <= delay;
      e_enable_br <= 1'b0;
      br_active <= 1'b0;
      br_cube <= 32'd0;
      br_step <= 3'd0;
    end else begin
      paused <= e_pause_qb ? 1'b1 : e_resume_qb ? 1'b0 : paused;
      e_enable_br <= 1'b0;
      if (state == WAIT) begin
        br_active <= 1'b0;
        br_cube <= 32'd0;
        br_step <= 3'd0;
      end
      if (!paused)
        case (state)
          IDLE: ;
          WAIT:
            if (timer == 32'd0) begin
              state <= LAUNCH;
              e_enable_br <= 1'b1;
              e_move_br <= lfsr[6:0];
              side <= lfsr[7];
              e_XY0_br <= lfsr[7] ? XY_SPAWN_R : XY_SPAWN_L;
              br_active <= 1'b1;
              row <= 3'd0;
            end else timer <= timer - 32'd1;
          LAUNCH: state <= ACTIVE;
          ACTIVE:
            if (br_kill) begin
              state <= WAIT;
              timer <= delay;
            end else if (done_move) begin
              br_step <= nstep;
              row <= nrow;
              idx <= nidx;
              br_cube <= cube_onehot(nidx);
              if (nstep == N_MOVES) begin
                state <= WAIT;
                timer <= delay;
              end
            end
        endcase
    end
endmodule

// File: tb/tb_boule_rouge_ctrl.sv
// tb_boule_rouge_ctrl: randomized self-checking bench against a pyramid-geometry reference model
module tb_boule_rouge_ctrl;
  localparam logic [20:0] XY_L = {11'd300, 10'd200};
  localparam logic [20:0] XY_R = {11'd300, 10'd280};
  localparam int D = 20;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic e_start_qb = 1'b0;
  logic e_pause_qb = 1'b0;
  logic e_resume_qb = 1'b0;
  logic done_move = 1'b0;
  logic br_kill = 1'b0;
  logic e_enable_br;
  logic [6:0] e_move_br;
  logic [20:0] e_XY0_br;
  logic br_active;
  logic [31:0] br_cube;
  logic [2:0] br_step;
  int n_cmp = 0;
  int n_bad = 0;
  int dly;
  logic [15:0] m_lfsr, m_prev;
  logic m_paused;
  logic [6:0] pat;
  logic sd;
  always #5 clk = ~clk;
  boule_rouge_ctrl #(
    .SPAWN_DELAY(32'd20),
    .JITTER_SHIFT(5'd0),
    .N_MOVES(3'd7),
    .XY_SPAWN_L(XY_L),
    .XY_SPAWN_R(XY_R),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .e_start_qb(e_start_qb),
    .e_pause_qb(e_pause_qb),
    .e_resume_qb(e_resume_qb),
    .done_move(done_move),
    .br_kill(br_kill),
    .e_enable_br(e_enable_br),
    .e_move_br(e_move_br),
    .e_XY0_br(e_XY0_br),
    .br_active(br_active),
    .br_cube(br_cube),
    .br_step(br_step)
  );
  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
      m_paused <= 1'b0;
    end else begin
      m_prev <= m_lfsr;
      if (!m_paused) m_lfsr <= lstep(m_lfsr);
      m_paused <= e_start_qb ? 1'b0 : e_pause_qb ? 1'b1 : e_resume_qb ? 1'b0 : m_paused;
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, 32'(e_enable_br), 32'd0);
    chk({tag, "_active"}, 32'(br_active), 32'd0);
    chk({tag, "_step"}, 32'(br_step), 32'd0);
    chk({tag, "_cube"}, br_cube, 32'd0);
    chk({tag, "_move"}, 32'(e_move_br), 32'd0);
    chk({tag, "_xy"}, 32'(e_XY0_br), 32'd0);
  endtask
  task automatic wait_launch(input int exp, input string tag);
    int cnt = 0;
    while (cnt < 300) begin
      tick();
      cnt++;
      if (e_enable_br) break;
    end
    chk({tag, "_delay"}, cnt, exp);
    chk({tag, "_move"}, 32'(e_move_br), 32'(m_prev[6:0]));
    chk({tag, "_xy"}, 32'(e_XY0_br), 32'(m_prev[7] ? XY_R : XY_L));
    chk({tag, "_active"}, 32'(br_active), 32'd1);
    chk({tag, "_step0"}, 32'(br_step), 32'd0);
    pat = m_prev[6:0];
    sd = m_prev[7];
    tick();
    chk({tag, "_pulse1"}, 32'(e_enable_br), 32'd0);
  endtask
  task automatic run_ball(input int kill_at, input int pause_at);
    int r = 0;
    int p = 0;
    for (int k = 1; k <= 7; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (k == pause_at) begin
        e_pause_qb = 1'b1;
        tick();
        e_pause_qb = 1'b0;
        done_move = 1'b1;
        br_kill = 1'b1;
        repeat (3) tick();
        done_move = 1'b0;
        br_kill = 1'b0;
        chk("pause_step", 32'(br_step), k - 1);
        chk("pause_active", 32'(br_active), 32'd1);
        e_resume_qb = 1'b1;
        tick();
        e_resume_qb = 1'b0;
      end
      done_move = 1'b1;
      br_kill = (k == kill_at);
      tick();
      done_move = 1'b0;
      br_kill = 1'b0;
      if (k == kill_at) begin
        chk("kill_step", 32'(br_step), k - 1);
        break;
      end
      if (k == 1) begin
        r = 2;
        p = 1 + int'(sd);
      end else begin
        p += int'(pat[k-2]);
        r++;
      end
      chk("step", 32'(br_step), k);
      chk("cube", br_cube, (r <= 7) ? (32'd1 << (r * (r - 1) / 2 + p - 1)) : 32'd0);
    end
    dly = D + int'(m_prev[3:0]);
    tick();
    chk("end_active", 32'(br_active), 32'd0);
    chk("end_step", 32'(br_step), 32'd0);
    chk("end_cube", br_cube, 32'd0);
    chk("hold_move", 32'(e_move_br), 32'(pat));
    chk("hold_xy", 32'(e_XY0_br), 32'(sd ? XY_R : XY_L));
  endtask
  initial begin
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    repeat (5) tick();
    chk("idle_en", 32'(e_enable_br), 32'd0);
    chk("idle_active", 32'(br_active), 32'd0);
    e_start_qb = 1'b1;
    tick();
    e_start_qb = 1'b0;
    dly = D + int'(m_prev[3:0]);
    wait_launch(dly + 1, "start");
    repeat (6) begin
      run_ball(0, 0);
      wait_launch(dly, "ball");
    end
    run_ball(4, 0);
    wait_launch(dly, "kill");
    run_ball(0, 3);
    wait_launch(dly, "apause");
    run_ball(0, 0);
    repeat (5) tick();
    e_pause_qb = 1'b1;
    tick();
    e_pause_qb = 1'b0;
    repeat (99) begin
      done_move = 1'($urandom);
      tick();
    end
    done_move = 1'b0;
    chk("wpause_active", 32'(br_active), 32'd0);
    chk("wpause_en", 32'(e_enable_br), 32'd0);
    e_resume_qb = 1'b1;
    tick();
    e_resume_qb = 1'b0;
    wait_launch(dly - 6, "wpause");
    done_move = 1'b1;
    tick();
    tick();
    done_move = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_zero("areset");
    reset = 1'b0;
    tick();
    e_start_qb = 1'b1;
    tick();
    e_start_qb = 1'b0;
    repeat (4) tick();
    e_pause_qb = 1'b1;
    tick();
    e_pause_qb = 1'b0;
    repeat (10) tick();
    e_start_qb = 1'b1;
    tick();
    e_start_qb = 1'b0;
    dly = D + int'(m_prev[3:0]);
    wait_launch(dly + 1, "restart");
    run_ball(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/boule_rouge_ctrl.md
Name: boule_rouge_ctrl

Overview:
Upstream controller for the red-ball layer. It decides when a red ball spawns, on which top-row cube (2 or 3) it appears, and the 7-step move pattern. It hands these to the layer as e_enable_br / e_XY0_br / e_move_br, then counts the layer's done_move pulses to track the ball's current cube as a one-hot pyramid position. It also honours game start/pause/resume and a collision kill.

Parameters:
SPAWN_DELAY, 32'd50_000_000, base clock cycles between ball end and next spawn
JITTER_SHIFT, 5'd16, left shift applied to the 4-bit random jitter added to SPAWN_DELAY
N_MOVES, 3'd7, done_move pulses after launch that end a ball (1 landing + 6 moves)
XY_SPAWN_L, {11'd300,10'd200}, {x,y} spawn for cube 2
XY_SPAWN_R, {11'd300,10'd280}, {x,y} spawn for cube 3
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
e_start_qb  in  1  game start/restart pulse
e_pause_qb  in  1  pause request
e_resume_qb  in  1  resume request
done_move  in  1  one-cycle pulse from layer: spawn landing or move completed
br_kill  in  1  collision with Q*bert; ends current ball
e_enable_br  out  1  one-cycle launch pulse to layer
e_move_br  out  7  move pattern; bit i = direction of move i+1 (0 = left child, 1 = right child)
e_XY0_br  out  21  spawn {x[10:0], y[9:0]}, stable while ball active
br_active  out  1  ball on pyramid (LAUNCH or ACTIVE)
br_cube  out  32  one-hot cube position, bit k = cube k+1; 0 when no ball or off pyramid
br_step  out  3  done_move pulses counted for current ball

Behaviour:
- Reset (async): state IDLE, paused=0, lfsr=LFSR_SEED. All outputs 0, timer 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle when not paused (all states).
- States:
  - IDLE: e_start_qb -> WAIT.
  - WAIT: on entry, timer <= SPAWN_DELAY + (lfsr[3:0] << JITTER_SHIFT). Decrement each unpaused cycle; at 0 -> LAUNCH.
  - LAUNCH (1 cycle): e_move_br <= lfsr[6:0]; side <= lfsr[7]; e_XY0_br <= side ? XY_SPAWN_R : XY_SPAWN_L; e_enable_br=1 this cycle only; br_step<=0; row<=0 -> ACTIVE.
  - ACTIVE: per done_move, br_step+1.
    - First pulse: row=2, index=2+side.
    - Pulse k≥2: index <= index + row + e_move_br[k-2], row+1; if the new row >7, index <= 0 (fell off).
    - br_cube = (index==0) ? 0 : 1<<(index-1).
    - br_step reaching N_MOVES -> WAIT.
    - br_kill -> WAIT (same cycle as done_move: kill wins, step not counted).
- Leaving ACTIVE: br_cube, br_step, br_active clear next cycle. e_move_br and e_XY0_br hold their last values.
- Index arithmetic is 5-bit unsigned, max 28. Row is 3-bit.
- Pause: e_pause_qb sets paused. While paused: timer, LFSR and state frozen; done_move and br_kill ignored. e_resume_qb clears paused.
- e_start_qb in any state (paused or not): paused=0, br_* cleared, -> WAIT (fresh timer). Start has priority over pause/resume/kill in the same cycle.
- e_start_qb and e_pause_qb in the same cycle: start wins, paused stays 0.
- Latency: done_move -> br_cube/br_step update 1 cycle later. Timer 0 -> e_enable_br 1 cycle later.

Decomposition:
- Package br_pkg: brctl_state_t enum {IDLE, WAIT, LAUNCH, ACTIVE}; cube one-hot constants TOP, R02..R22, L03..L28; XY packing widths (X 11, Y 10).
- One sub-module: br_lfsr16 (seed param, enable, 16-bit state out).
- Index/row update stays inline.

Test Plan:
1. Reset, e_start_qb, SPAWN_DELAY=20, JITTER_SHIFT=0 -> exactly one e_enable_br pulse 21..36 cycles after start; e_XY0_br equals XY_SPAWN_L or XY_SPAWN_R matching lfsr[7] at launch.
2. Force pattern 7'b0000000, side=0, 7 done_move pulses -> br_cube sequence 1<<1 (cube 2), cubes 4,7,11,16,22,29→0 (off), then br_active=0, state WAIT.
3. Pattern 7'b1111111, side=1 -> cubes 3,6,10,15,21,28, then 0 after the 7th pulse; one-hot R/L edge constants match.
4. e_pause_qb mid-WAIT for 100 cycles, done_move pulsed during pause -> launch delayed by 100 cycles, br_step unchanged; e_resume_qb resumes countdown.
5. br_kill and done_move in the same cycle at step 3 -> br_step stays 3 then clears, br_cube=0, new WAIT delay loaded.
6. Async reset asserted mid-ACTIVE between clock edges -> all outputs 0 immediately. e_start_qb during pause -> paused=0, WAIT restarted.
